// File: rtl/pcm_bus_arbiter.sv
// pcm_bus_arbiter
//   Shares the YM2610 PCM nibble mux/IO pins and the single PCM memory read
//   port between the ADPCM-A reader (interruptible) and the ADPCM-B reader
//   (non-interruptible).
//
//   Mux side: B pre-empts A by asserting a_pause. Each change of owner goes
//   through TURNAROUND safe-state cycles, during which the pins sit at their
//   reset values. B keeps the mux until it drops b_mux_needed. A has no grant
//   handshake: it simply resumes (restarting its step) when a_pause falls.
//
//   Memory side: round-robin between the A and B read requests. A request is
//   latched at grant. mem_valid then stays high until mem_ready, even if the
//   requester withdraws. The completion pulse goes back to the owner only if
//   that owner's valid is still high; otherwise the response is dropped.
//
// Handshake: a requester holds *_mem_valid (and its address) until it sees
//   *_mem_ready. The memory holds mem_ready low until it completes the
//   transfer that mem_valid/mem_addr present, then pulses it for one cycle.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   a_mux_needed / a_pause          A mux request / pause A reader
//   a_mux_sel..a_pcm_load           A pin drive (3/1/4/1/1 bits)
//   b_mux_needed / b_mux_grant      B mux request / B owns the mux
//   b_mux_sel..b_pcm_load           B pin drive
//   mux_sel..pcm_load               pin outputs
//   a_mem_*, b_mem_*                requester read ports
//   mem_valid/addr/ready/rdata      shared PCM memory read port
//   preempt_count                   A->B pre-emptions since reset (wraps)
//   dbg_mux_state, dbg_mem_state    current FSM states, for observation
module pcm_bus_arbiter #(
  parameter int TURNAROUND = 1,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_mux_needed,
  output logic              a_pause,
  input  logic [2:0]        a_mux_sel,
  input  logic              a_mux_oe_n,
  input  logic [3:0]        a_ym_io_out,
  input  logic              a_ym_io_en,
  input  logic              a_pcm_load,
  input  logic              b_mux_needed,
  output logic              b_mux_grant,
  input  logic [2:0]        b_mux_sel,
  input  logic              b_mux_oe_n,
  input  logic [3:0]        b_ym_io_out,
  input  logic              b_ym_io_en,
  input  logic              b_pcm_load,
  output logic [2:0]        mux_sel,
  output logic              mux_oe_n,
  output logic [3:0]        ym_io_out,
  output logic              ym_io_en,
  output logic              pcm_load,
  input  logic              a_mem_valid,
  input  logic [ADDR_W-1:0] a_mem_addr,
  output logic              a_mem_ready,
  output logic [7:0]        a_mem_rdata,
  input  logic              b_mem_valid,
  input  logic [ADDR_W-1:0] b_mem_addr,
  output logic              b_mem_ready,
  output logic [7:0]        b_mem_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       preempt_count,
  output logic [1:0]        dbg_mux_state,
  output logic [1:0]        dbg_mem_state
);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_A = 2'd1, M_TURN = 2'd2, M_B = 2'd3} mux_state_t;
  typedef enum logic [1:0] {P_IDLE = 2'd0, P_A = 2'd1, P_B = 2'd2} mem_state_t;

  localparam int CNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  // The counter runs TURNAROUND-1 down to 0, so M_TURN lasts TURNAROUND cycles.
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  // ---------------- mux FSM ----------------
  mux_state_t       mstate_q, mstate_d;
  logic [CNT_W-1:0] turn_q, turn_d;
  logic [15:0]      preempt_q;
  logic             preempt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      mstate_q  <= M_IDLE;
      turn_q    <= '0;
      preempt_q <= 16'd0;
    end else begin
      mstate_q <= mstate_d;
      turn_q   <= turn_d;
      if (preempt_inc) preempt_q <= preempt_q + 16'd1;
    end
  end

  always_comb begin
    mstate_d    = mstate_q;
    turn_d      = turn_q;
    preempt_inc = 1'b0;
    mux_sel     = 3'b000;
    mux_oe_n    = 1'b1;
    ym_io_out   = 4'h0;
    ym_io_en    = 1'b0;
    pcm_load    = 1'b0;
    case (mstate_q)
      M_IDLE: begin
        // B wins a tie.
        if (b_mux_needed)      mstate_d = M_B;
        else if (a_mux_needed) mstate_d = M_A;
      end
      M_A: begin
        mux_sel   = a_mux_sel;
        mux_oe_n  = a_mux_oe_n;
        ym_io_out = a_ym_io_out;
        ym_io_en  = a_ym_io_en;
        pcm_load  = a_pcm_load;
        if (b_mux_needed) begin
          preempt_inc = 1'b1;
          if (TURNAROUND == 0) begin
            mstate_d = M_B;
          end else begin
            mstate_d = M_TURN;
            turn_d   = TURN_LOAD;
          end
        end else if (!a_mux_needed) begin
          mstate_d = M_IDLE;
        end
      end
      M_TURN: begin
        // Safe pin values come from the defaults above.
        if (turn_q == '0) mstate_d = b_mux_needed ? M_B : M_IDLE;
        else              turn_d   = turn_q - CNT_W'(1);
      end
      M_B: begin
        mux_sel   = b_mux_sel;
        mux_oe_n  = b_mux_oe_n;
        ym_io_out = b_ym_io_out;
        ym_io_en  = b_ym_io_en;
        pcm_load  = b_pcm_load;
        if (!b_mux_needed) begin
          if (TURNAROUND == 0) begin
            mstate_d = M_IDLE;
          end else begin
            mstate_d = M_TURN;
            turn_d   = TURN_LOAD;
          end
        end
      end
      default: mstate_d = M_IDLE;
    endcase
  end

  // Both are decoded from the state register only, so they are glitch-free.
  assign a_pause       = (mstate_q == M_TURN) || (mstate_q == M_B);
  assign b_mux_grant   = (mstate_q == M_B);
  assign preempt_count = preempt_q;
  assign dbg_mux_state = mstate_q;

  // ---------------- memory FSM ----------------
  mem_state_t        pstate_q, pstate_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_b_q, last_b_d;   // 1: B was served last

  always_ff @(posedge clk) begin
    if (reset) begin
      pstate_q <= P_IDLE;
      addr_q   <= '0;
      last_b_q <= 1'b1;
    end else begin
      pstate_q <= pstate_d;
      addr_q   <= addr_d;
      last_b_q <= last_b_d;
    end
  end

  always_comb begin
    pstate_d    = pstate_q;
    addr_d      = addr_q;
    last_b_d    = last_b_q;
    a_mem_ready = 1'b0;
    b_mem_ready = 1'b0;
    case (pstate_q)
      P_IDLE: begin
        if (a_mem_valid && (!b_mem_valid || last_b_q)) begin
          pstate_d = P_A;
          addr_d   = a_mem_addr;
        end else if (b_mem_valid) begin
          pstate_d = P_B;
          addr_d   = b_mem_addr;
        end
      end
      P_A: begin
        if (mem_ready) begin
          // A withdrawn request still completes; the data is just dropped.
          a_mem_ready = a_mem_valid;
          last_b_d    = 1'b0;
          pstate_d    = P_IDLE;
        end
      end
      P_B: begin
        if (mem_ready) begin
          b_mem_ready = b_mem_valid;
          last_b_d    = 1'b1;
          pstate_d    = P_IDLE;
        end
      end
      default: pstate_d = P_IDLE;
    endcase
  end

  assign mem_valid     = (pstate_q != P_IDLE);
  assign mem_addr      = addr_q;
  assign a_mem_rdata   = mem_rdata;
  assign b_mem_rdata   = mem_rdata;
  assign dbg_mem_state = pstate_q;

endmodule

// File: tb/tb_pcm_bus_arbiter.sv
// Testbench for pcm_bus_arbiter (TURNAROUND=1, ADDR_W=24).
// Mux behaviour: table of per-cycle {inputs, expected outputs}.
// Memory behaviour: hand-written multi-cycle sequences with an address queue.
module tb_pcm_bus_arbiter;

  localparam int ADDR_W = 24;

  // A and B drive distinct pin patterns so the owner is visible on the pins.
  localparam logic [2:0] A_SEL = 3'b100;
  localparam logic [3:0] A_IO  = 4'hA;
  localparam logic [2:0] B_SEL = 3'b011;
  localparam logic [3:0] B_IO  = 4'h5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              a_mux_needed, b_mux_needed;
  logic              a_pause, b_mux_grant;
  logic [2:0]        a_mux_sel, b_mux_sel, mux_sel;
  logic              a_mux_oe_n, b_mux_oe_n, mux_oe_n;
  logic [3:0]        a_ym_io_out, b_ym_io_out, ym_io_out;
  logic              a_ym_io_en, b_ym_io_en, ym_io_en;
  logic              a_pcm_load, b_pcm_load, pcm_load;
  logic              a_mem_valid, b_mem_valid, a_mem_ready, b_mem_ready;
  logic [ADDR_W-1:0] a_mem_addr, b_mem_addr, mem_addr;
  logic [7:0]        a_mem_rdata, b_mem_rdata, mem_rdata;
  logic              mem_valid, mem_ready;
  logic [15:0]       preempt_count;
  logic [1:0]        dbg_mux_state, dbg_mem_state;

  pcm_bus_arbiter #(.TURNAROUND(1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_mux_needed(a_mux_needed), .a_pause(a_pause),
    .a_mux_sel(a_mux_sel), .a_mux_oe_n(a_mux_oe_n), .a_ym_io_out(a_ym_io_out),
    .a_ym_io_en(a_ym_io_en), .a_pcm_load(a_pcm_load),
    .b_mux_needed(b_mux_needed), .b_mux_grant(b_mux_grant),
    .b_mux_sel(b_mux_sel), .b_mux_oe_n(b_mux_oe_n), .b_ym_io_out(b_ym_io_out),
    .b_ym_io_en(b_ym_io_en), .b_pcm_load(b_pcm_load),
    .mux_sel(mux_sel), .mux_oe_n(mux_oe_n), .ym_io_out(ym_io_out),
    .ym_io_en(ym_io_en), .pcm_load(pcm_load),
    .a_mem_valid(a_mem_valid), .a_mem_addr(a_mem_addr),
    .a_mem_ready(a_mem_ready), .a_mem_rdata(a_mem_rdata),
    .b_mem_valid(b_mem_valid), .b_mem_addr(b_mem_addr),
    .b_mem_ready(b_mem_ready), .b_mem_rdata(b_mem_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .preempt_count(preempt_count),
    .dbg_mux_state(dbg_mux_state), .dbg_mem_state(dbg_mem_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner code: 0 = safe values, 1 = A pins, 2 = B pins.
  task automatic check_pins(input string tag, input logic [1:0] owner);
    logic [2:0] e_sel;
    logic       e_oe_n;
    logic [3:0] e_io;
    logic       e_en;
    logic       e_ld;
    case (owner)
      2'd1:    begin e_sel = A_SEL; e_oe_n = 1'b0; e_io = A_IO; e_en = 1'b1; e_ld = 1'b1; end
      2'd2:    begin e_sel = B_SEL; e_oe_n = 1'b0; e_io = B_IO; e_en = 1'b1; e_ld = 1'b0; end
      default: begin e_sel = 3'b000; e_oe_n = 1'b1; e_io = 4'h0; e_en = 1'b0; e_ld = 1'b0; end
    endcase
    check({tag, ".mux_sel"},   32'(mux_sel),   32'(e_sel));
    check({tag, ".mux_oe_n"},  32'(mux_oe_n),  32'(e_oe_n));
    check({tag, ".ym_io_out"}, 32'(ym_io_out), 32'(e_io));
    check({tag, ".ym_io_en"},  32'(ym_io_en),  32'(e_en));
    check({tag, ".pcm_load"},  32'(pcm_load),  32'(e_ld));
  endtask

  // ---------------- mux vector table ----------------
  typedef struct {
    logic        rst;
    logic        a_need;
    logic        b_need;
    logic [1:0]  exp_owner;
    logic        exp_pause;
    logic        exp_grant;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_state;   // 0 IDLE, 1 A, 2 TURN, 3 B
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    reset        = 1'b1;
    a_mux_needed = 1'b0;  b_mux_needed = 1'b0;
    a_mux_sel    = A_SEL; a_mux_oe_n = 1'b0; a_ym_io_out = A_IO; a_ym_io_en = 1'b1; a_pcm_load = 1'b1;
    b_mux_sel    = B_SEL; b_mux_oe_n = 1'b0; b_ym_io_out = B_IO; b_ym_io_en = 1'b1; b_pcm_load = 1'b0;
    a_mem_valid  = 1'b0;  b_mem_valid = 1'b0;
    a_mem_addr   = '0;    b_mem_addr  = '0;
    mem_ready    = 1'b0;  mem_rdata   = 8'h00;

    //              rst   a     b     owner pause grant cnt     state
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 2'd0}; // reset, inputs active
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 2'd1}; // A gets mux next cycle
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 2'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 16'd1, 2'd2}; // B rises at N: pause, safe
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'd1, 2'd3}; // grant at N+2
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'd1, 2'd3};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'd1, 2'd2}; // B drops at M: safe
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1, 2'd0}; // idle, pause released
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd1, 2'd1}; // A pins at M+3
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1, 2'd0}; // A releases
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 16'd1, 2'd3}; // tie: B, no preempt
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd1, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'd1, 2'd3}; // B back during turn
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd1, 2'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1, 2'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd1, 2'd1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 2'd0}; // reset mid-operation
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 2'd1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 16'd1, 2'd2};

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      reset        = vecs[i].rst;
      a_mux_needed = vecs[i].a_need;
      b_mux_needed = vecs[i].b_need;
      if (vecs[i].rst) begin
        // Exercise memory inputs during reset too; they must have no effect.
        a_mem_valid = 1'b1; b_mem_valid = 1'b1; mem_ready = 1'b1;
      end
      tick();
      a_mem_valid = 1'b0; b_mem_valid = 1'b0; mem_ready = 1'b0;
      check_pins(tag, vecs[i].exp_owner);
      check({tag, ".a_pause"},       32'(a_pause),       32'(vecs[i].exp_pause));
      check({tag, ".b_mux_grant"},   32'(b_mux_grant),   32'(vecs[i].exp_grant));
      check({tag, ".preempt_count"}, 32'(preempt_count), 32'(vecs[i].exp_cnt));
      check({tag, ".mux_state"},     32'(dbg_mux_state), 32'(vecs[i].exp_state));
      if (vecs[i].rst) begin
        check({tag, ".mem_valid"},   32'(mem_valid),   32'd0);
        check({tag, ".a_mem_ready"}, 32'(a_mem_ready), 32'd0);
        check({tag, ".b_mem_ready"}, 32'(b_mem_ready), 32'd0);
      end
    end
    a_mux_needed = 1'b0;
    b_mux_needed = 1'b0;
    tick();
    tick();

    // ---------------- memory: simultaneous requests ----------------
    // last_mem is B after reset, so A is served first.
    exp_q.push_back(24'h000123);
    exp_q.push_back(24'h400000);
    a_mem_valid = 1'b1; a_mem_addr = 24'h000123;
    b_mem_valid = 1'b1; b_mem_addr = 24'h400000;
    tick();
    check("rr1.mem_valid", 32'(mem_valid), 32'd1);
    check("rr1.mem_addr",  32'(mem_addr),  32'(exp_q[0]));
    a_mem_addr = 24'hFFFFFF;              // address must stay latched
    tick();
    check("rr1.hold_valid", 32'(mem_valid), 32'd1);
    check("rr1.hold_addr",  32'(mem_addr),  32'(exp_q.pop_front()));
    mem_ready = 1'b1; mem_rdata = 8'h5A;
    #1;
    check("rr1.a_mem_ready", 32'(a_mem_ready), 32'd1);
    check("rr1.b_mem_ready", 32'(b_mem_ready), 32'd0);
    check("rr1.a_mem_rdata", 32'(a_mem_rdata), 32'h5A);
    tick();
    mem_ready = 1'b0; a_mem_valid = 1'b0;
    check("rr1.valid_drop", 32'(mem_valid), 32'd0);
    tick();
    check("rr2.mem_valid", 32'(mem_valid), 32'd1);
    check("rr2.mem_addr",  32'(mem_addr),  32'(exp_q.pop_front()));
    mem_ready = 1'b1; mem_rdata = 8'hC3;
    #1;
    check("rr2.b_mem_ready", 32'(b_mem_ready), 32'd1);
    check("rr2.a_mem_ready", 32'(a_mem_ready), 32'd0);
    check("rr2.b_mem_rdata", 32'(b_mem_rdata), 32'hC3);
    tick();
    mem_ready = 1'b0; b_mem_valid = 1'b0;
    check("rr2.valid_drop", 32'(mem_valid), 32'd0);
    tick();

    // ---------------- memory: A withdraws mid-read ----------------
    a_mem_valid = 1'b1; a_mem_addr = 24'h0000AA;
    tick();
    check("wd.mem_valid", 32'(mem_valid), 32'd1);
    check("wd.mem_addr",  32'(mem_addr),  32'h0000AA);
    a_mem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wd.held%0d", k), 32'(mem_valid), 32'd1);
    end
    mem_ready = 1'b1;
    #1;
    check("wd.a_mem_ready", 32'(a_mem_ready), 32'd0);
    check("wd.b_mem_ready", 32'(b_mem_ready), 32'd0);
    tick();
    mem_ready = 1'b0;
    check("wd.valid_drop", 32'(mem_valid), 32'd0);
    check("wd.mem_state",  32'(dbg_mem_state), 32'd0);

    // ---------------- memory: round-robin after A was last ----------------
    a_mem_valid = 1'b1; a_mem_addr = 24'h111111;
    b_mem_valid = 1'b1; b_mem_addr = 24'h222222;
    tick();
    check("rr3.mem_addr",  32'(mem_addr),      32'h222222);
    check("rr3.mem_state", 32'(dbg_mem_state), 32'd2);
    mem_ready = 1'b1;
    #1;
    check("rr3.b_mem_ready", 32'(b_mem_ready), 32'd1);
    tick();
    mem_ready = 1'b0; b_mem_valid = 1'b0;
    tick();
    check("rr4.mem_addr", 32'(mem_addr), 32'h111111);
    mem_ready = 1'b1;
    #1;
    check("rr4.a_mem_ready", 32'(a_mem_ready), 32'd1);
    tick();
    mem_ready = 1'b0; a_mem_valid = 1'b0;
    tick();
    check("end.mem_valid", 32'(mem_valid), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
